// File: rtl/uart_hex_dump.sv
// uart_hex_dump: turns binary words into an ASCII hexadecimal byte stream,
// most significant nibble first, optionally terminated by CR LF. The byte
// side is a valid/ready source intended to feed a UART transmitter directly.
// byte_out_valid/byte_out_data are pure registers, so the transmitter's
// ready never reaches them combinationally.

module uart_hex_dump #(
    parameter int WORD_WIDTH = 32,
    parameter bit EMIT_CRLF  = 1'b1,
    parameter bit UPPERCASE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word_in_data,
    input  logic                  word_in_valid,
    output logic                  word_in_ready,
    output logic [7:0]            byte_out_data,
    output logic                  byte_out_valid,
    input  logic                  byte_out_ready
);

    localparam int NIBBLES = WORD_WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEX  = 2'd1,
        S_CR   = 2'd2,
        S_LF   = 2'd3
    } state_t;

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_valid;
    logic [7:0]            r_data;

    logic [WORD_WIDTH-1:0] w_shift_next;

    // Map one nibble to its ASCII hex digit; letter case chosen at elaboration.
    function automatic logic [7:0] f_hex_ascii(input logic [3:0] nib);
        logic [7:0] v;
        v = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + v;
        end else if (UPPERCASE) begin
            return 8'h41 + (v - 8'd10);
        end else begin
            return 8'h61 + (v - 8'd10);
        end
    endfunction

    assign w_shift_next   = r_shift << 4;
    // Ready is withheld during the reset cycle itself, then follows IDLE.
    assign word_in_ready  = (r_state == S_IDLE) && !rst;
    assign byte_out_valid = r_valid;
    assign byte_out_data  = r_data;

    // Formatter FSM: captures a word, walks its nibbles, appends CR LF; the
    // next output byte is precomputed so the outputs stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (word_in_valid) begin
                        r_shift <= word_in_data;
                        r_cnt   <= CNT_W'(NIBBLES - 1);
                        r_state <= S_HEX;
                        r_valid <= 1'b1;
                        r_data  <= f_hex_ascii(word_in_data[WORD_WIDTH-1 -: 4]);
                    end
                end
                S_HEX: begin
                    if (byte_out_ready) begin
                        r_shift <= w_shift_next;
                        if (r_cnt == '0) begin
                            // Last digit taken; the counter stops here, never wraps.
                            if (EMIT_CRLF) begin
                                r_state <= S_CR;
                                r_data  <= 8'h0D;
                            end else begin
                                r_state <= S_IDLE;
                                r_valid <= 1'b0;
                                r_data  <= 8'h00;
                            end
                        end else begin
                            r_cnt  <= r_cnt - CNT_W'(1);
                            r_data <= f_hex_ascii(w_shift_next[WORD_WIDTH-1 -: 4]);
                        end
                    end
                end
                S_CR: begin
                    if (byte_out_ready) begin
                        r_state <= S_LF;
                        r_data  <= 8'h0A;
                    end
                end
                S_LF: begin
                    if (byte_out_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_data  <= 8'h00;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_data  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_dump.sv
// Bench for uart_hex_dump: three instances cover the default configuration,
// lowercase without CR LF, and an 8-bit word. Expected byte streams come
// from a digit-by-digit model of the hex text.

module tb_uart_hex_dump;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: WORD_WIDTH=32, EMIT_CRLF=1, UPPERCASE=1
    logic [31:0] a_wd;
    logic        a_wv, a_wr, a_bv, a_br;
    logic [7:0]  a_bd;
    // Instance B: WORD_WIDTH=32, EMIT_CRLF=0, UPPERCASE=0
    logic [31:0] b_wd;
    logic        b_wv, b_wr, b_bv, b_br;
    logic [7:0]  b_bd;
    // Instance C: WORD_WIDTH=8, EMIT_CRLF=1, UPPERCASE=1
    logic [7:0]  c_wd;
    logic        c_wv, c_wr, c_bv, c_br;
    logic [7:0]  c_bd;

    uart_hex_dump #(.WORD_WIDTH(32), .EMIT_CRLF(1'b1), .UPPERCASE(1'b1)) u_a (
        .clk(clk), .rst(rst),
        .word_in_data(a_wd), .word_in_valid(a_wv), .word_in_ready(a_wr),
        .byte_out_data(a_bd), .byte_out_valid(a_bv), .byte_out_ready(a_br));

    uart_hex_dump #(.WORD_WIDTH(32), .EMIT_CRLF(1'b0), .UPPERCASE(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .word_in_data(b_wd), .word_in_valid(b_wv), .word_in_ready(b_wr),
        .byte_out_data(b_bd), .byte_out_valid(b_bv), .byte_out_ready(b_br));

    uart_hex_dump #(.WORD_WIDTH(8), .EMIT_CRLF(1'b1), .UPPERCASE(1'b1)) u_c (
        .clk(clk), .rst(rst),
        .word_in_data(c_wd), .word_in_valid(c_wv), .word_in_ready(c_wr),
        .byte_out_data(c_bd), .byte_out_valid(c_bv), .byte_out_ready(c_br));

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Reference model: the text a word should print as.
    task automatic build_exp(input logic [31:0] w, input int nib, input bit crlf, input bit upper);
        exp_q.delete();
        for (int i = nib - 1; i >= 0; i--) begin
            int n;
            n = int'((w >> (4 * i)) & 32'hF);
            if (n < 10) exp_q.push_back(8'(48 + n));
            else        exp_q.push_back(8'((upper ? 65 : 97) + n - 10));
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_wv = 1'b0; b_wv = 1'b0; c_wv = 1'b0;
        a_br = 1'b1; b_br = 1'b1; c_br = 1'b1;
        a_wd = 32'h0; b_wd = 32'h0; c_wd = 8'h0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (a_wr !== 1'b0 || b_wr !== 1'b0 || c_wr !== 1'b0) begin
            n_errors++; $display("FAIL reset_ready_low: got %b%b%b want 000", a_wr, b_wr, c_wr);
        end
        n_checks++;
        if (a_bv !== 1'b0 || a_bd !== 8'h00 || b_bv !== 1'b0 || c_bv !== 1'b0) begin
            n_errors++; $display("FAIL reset_outputs: got valid %b data %h want 0 00", a_bv, a_bd);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_wr !== 1'b1 || b_wr !== 1'b1 || c_wr !== 1'b1 || a_bv !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_ready: got %b%b%b valid %b want 111 0", a_wr, b_wr, c_wr, a_bv);
        end
    endtask

    // Fixed-latency check on instance A with ready held high.
    task automatic test_deadbeef;
        @(negedge clk);
        a_br = 1'b1;
        n_checks++;
        if (a_wr !== 1'b1) begin
            n_errors++; $display("FAIL deadbeef_ready_before: got %b want 1", a_wr);
        end
        a_wd = 32'hDEADBEEF; a_wv = 1'b1;
        build_exp(32'hDEADBEEF, 8, 1'b1, 1'b1);
        @(negedge clk);
        a_wv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (a_bv !== 1'b1 || a_bd !== exp_q[k] || a_wr !== 1'b0) begin
                n_errors++;
                $display("FAIL deadbeef_byte%0d: got valid %b data %h ready %b want 1 %h 0", k, a_bv, a_bd, a_wr, exp_q[k]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (a_wr !== 1'b1 || a_bv !== 1'b0) begin
            n_errors++; $display("FAIL deadbeef_idle_after: got ready %b valid %b want 1 0", a_wr, a_bv);
        end
    endtask

    // One word on instance A under random backpressure, with stall stability checks.
    task automatic run_a_random(input logic [31:0] w);
        bit stalled;
        logic [7:0] held;
        int cyc;
        build_exp(w, 8, 1'b1, 1'b1);
        got_q.delete();
        @(negedge clk);
        n_checks++;
        if (a_wr !== 1'b1) begin
            n_errors++; $display("FAIL rand_ready_before: got %b want 1", a_wr);
        end
        a_wd = w; a_wv = 1'b1; a_br = 1'b0;
        stalled = 1'b0; held = 8'h00; cyc = 0;
        @(negedge clk);
        a_wv = 1'b0;
        while (got_q.size() < exp_q.size() && cyc < 300) begin
            if (stalled) begin
                n_checks++;
                if (a_bv !== 1'b1 || a_bd !== held) begin
                    n_errors++; $display("FAIL stall_hold: got valid %b data %h want 1 %h", a_bv, a_bd, held);
                end
            end
            a_br = 1'($urandom_range(0, 1));
            if (a_bv === 1'b1 && a_br) got_q.push_back(a_bd);
            stalled = (a_bv === 1'b1) && !a_br;
            held = a_bd;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 300) begin
            n_errors++; $display("FAIL rand_timeout: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        n_checks++;
        if (a_wr !== 1'b1 || a_bv !== 1'b0) begin
            n_errors++; $display("FAIL rand_idle_after: got ready %b valid %b want 1 0", a_wr, a_bv);
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_errors++; $display("FAIL rand_byte%0d word %h: got %h want %h", k, w, got_q[k], exp_q[k]);
            end
        end
        a_br = 1'b1;
    endtask

    task automatic test_random_stall;
        run_a_random(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) run_a_random($urandom);
    endtask

    // Instance B: lowercase, no CR LF; fixed latency with ready high.
    task automatic test_lower_nocrlf;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w = (i == 0) ? 32'h0000ABCD : $urandom;
            build_exp(w, 8, 1'b0, 1'b0);
            @(negedge clk);
            b_br = 1'b1; b_wd = w; b_wv = 1'b1;
            @(negedge clk);
            b_wv = 1'b0;
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (b_bv !== 1'b1 || b_bd !== exp_q[k]) begin
                    n_errors++; $display("FAIL lower_byte%0d word %h: got valid %b data %h want 1 %h", k, w, b_bv, b_bd, exp_q[k]);
                end
                @(negedge clk);
            end
            n_checks++;
            if (b_bv !== 1'b0 || b_wr !== 1'b1) begin
                n_errors++; $display("FAIL lower_no_crlf: got valid %b data %h ready %b want 0 1", b_bv, b_bd, b_wr);
            end
        end
    endtask

    // Instance C: 8-bit words.
    task automatic test_width8;
        logic [7:0] w;
        for (int i = 0; i < 4; i++) begin
            w = (i == 0) ? 8'h5A : 8'($urandom);
            build_exp({24'h0, w}, 2, 1'b1, 1'b1);
            @(negedge clk);
            c_br = 1'b1; c_wd = w; c_wv = 1'b1;
            @(negedge clk);
            c_wv = 1'b0;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (c_bv !== 1'b1 || c_bd !== exp_q[k]) begin
                    n_errors++; $display("FAIL w8_byte%0d word %h: got valid %b data %h want 1 %h", k, w, c_bv, c_bd, exp_q[k]);
                end
                @(negedge clk);
            end
            n_checks++;
            if (c_bv !== 1'b0 || c_wr !== 1'b1) begin
                n_errors++; $display("FAIL w8_idle_after: got valid %b ready %b want 0 1", c_bv, c_wr);
            end
        end
    endtask

    // Instance A: valid held high across two words; second waits for the LF.
    task automatic test_back_to_back;
        logic [7:0] exp_all[$];
        int acc_cyc[2];
        int n_acc, cyc;
        bit switch_pending;
        build_exp(32'h00000001, 8, 1'b1, 1'b1);
        exp_all = exp_q;
        build_exp(32'hFFFFFFFF, 8, 1'b1, 1'b1);
        foreach (exp_q[k]) exp_all.push_back(exp_q[k]);
        got_q.delete();
        n_acc = 0; cyc = 0; switch_pending = 1'b0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        @(negedge clk);
        a_br = 1'b1; a_wd = 32'h00000001; a_wv = 1'b1;
        while (got_q.size() < 20 && cyc < 60) begin
            if (a_bv === 1'b1) got_q.push_back(a_bd);
            if (a_wv && a_wr === 1'b1) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++;
                switch_pending = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (switch_pending) begin
                if (n_acc == 1) a_wd = 32'hFFFFFFFF;
                else a_wv = 1'b0;
                switch_pending = 1'b0;
            end
        end
        a_wv = 1'b0;
        n_checks++;
        if (cyc >= 60 || n_acc != 2) begin
            n_errors++; $display("FAIL b2b_accepts: got %0d accepts %0d bytes want 2 20", n_acc, got_q.size());
        end
        n_checks++;
        if (acc_cyc[1] - acc_cyc[0] != 11) begin
            n_errors++; $display("FAIL b2b_spacing: got %0d want 11", acc_cyc[1] - acc_cyc[0]);
        end
        for (int k = 0; k < 20 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_all[k]) begin
                n_errors++; $display("FAIL b2b_byte%0d: got %h want %h", k, got_q[k], exp_all[k]);
            end
        end
    endtask

    // Instance A: reset pulse in the middle of a word discards the rest.
    task automatic test_reset_mid;
        build_exp(32'h12345678, 8, 1'b1, 1'b1);
        @(negedge clk);
        a_br = 1'b1; a_wd = 32'h12345678; a_wv = 1'b1;
        @(negedge clk);
        a_wv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (a_bv !== 1'b1 || a_bd !== exp_q[k]) begin
                n_errors++; $display("FAIL rmid_byte%0d: got valid %b data %h want 1 %h", k, a_bv, a_bd, exp_q[k]);
            end
            if (k == 2) rst = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (a_bv !== 1'b0 || a_wr !== 1'b0) begin
            n_errors++; $display("FAIL rmid_in_reset: got valid %b ready %b want 0 0", a_bv, a_wr);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_bv !== 1'b0 || a_wr !== 1'b1) begin
                n_errors++; $display("FAIL rmid_discard%0d: got valid %b data %h ready %b want 0 1", k, a_bv, a_bd, a_wr);
            end
        end
        run_a_random(32'h00000009);
    endtask

    initial begin
        test_reset();
        test_deadbeef();
        test_random_stall();
        test_lower_nocrlf();
        test_width8();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_hex_dump.md
# uart_hex_dump

Byte-stream formatter that sits directly upstream of the UART transmitter. It accepts binary words over a valid/ready handshake and emits each one as ASCII hexadecimal characters, most significant nibble first, optionally followed by CR LF. Its byte output plugs straight into the transmitter's byte valid/ready input, so debug logic can print register values over the serial line.

## Interface

- WORD_WIDTH, 32: input word width in bits; must be a multiple of 4 and at least 4. NIBBLES = WORD_WIDTH/4.
- EMIT_CRLF, 1: 1 = append 0x0D, 0x0A after the hex digits; 0 = hex digits only.
- UPPERCASE, 1: 1 = digits A–F encode as 0x41–0x46; 0 = digits a–f encode as 0x61–0x66.

- clk  input  1  clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- word_in_data  input  WORD_WIDTH  word to print.
- word_in_valid  input  1  word_in_data is valid.
- word_in_ready  output  1  block can accept a word this cycle.
- byte_out_data  output  8  ASCII character to the transmitter.
- byte_out_valid  output  1  byte_out_data is valid.
- byte_out_ready  input  1  transmitter accepts byte_out_data this cycle.

## Operation

- States: IDLE, HEX, CR, LF.
- IDLE:
  - word_in_ready = 1 and byte_out_valid = 0.
  - On word_in_valid, capture the word into a shift register, load the nibble counter with NIBBLES-1, and go to HEX.
- HEX:
  - byte_out_valid = 1; byte_out_data = ASCII of the top nibble of the shift register.
  - Nibbles 0–9 encode as 0x30–0x39. Nibbles 10–15 encode per UPPERCASE.
  - On byte_out_ready, shift the register left by 4 and decrement the counter.
  - If byte_out_ready arrives while the counter is 0: go to CR when EMIT_CRLF=1, otherwise go to IDLE.
- CR: byte_out_valid = 1, byte_out_data = 0x0D. On byte_out_ready, go to LF.
- LF: byte_out_valid = 1, byte_out_data = 0x0A. On byte_out_ready, go to IDLE.
- word_in_ready = 0 in every state except IDLE. Words offered while busy are not accepted; the source must hold them.
- The nibble counter is $clog2(NIBBLES) bits wide, minimum 1 bit. It never wraps, because leaving HEX happens at counter 0.
- byte_out_valid and byte_out_data are decoded only from registered state, never from byte_out_ready. This avoids a combinational path from the transmitter's ready.

## Timing

- Reset values:
  - state = IDLE, byte_out_valid = 0, byte_out_data = 0x00.
  - word_in_ready = 0 in the cycle rst is high, and 1 from the first cycle after rst deasserts.
  - The shift register and counter need no reset value.
- Latency: a word accepted at edge N puts byte_out_valid high from cycle N+1, carrying the first digit.
- Throughput: one byte per cycle while byte_out_ready stays high.
  - One word takes NIBBLES + 2·EMIT_CRLF output cycles.
  - One IDLE cycle follows between words, where the next word can be accepted.
  - Example: WORD_WIDTH=32, EMIT_CRLF=1 gives 11 cycles per word.
- Backpressure: while byte_out_valid=1 and byte_out_ready=0, byte_out_data and state must hold unchanged. byte_out_valid must not drop before the byte is taken.
- Simultaneous events: in IDLE, word_in_valid is sampled even if the previous LF was taken in the prior cycle. No bytes are dropped or repeated.
- Reset mid-operation: rst high at any edge returns to IDLE. byte_out_valid = 0 from the following cycle and the remaining characters of the word are discarded. After reset deasserts, the next word prints from its first digit.

## Test plan

- Default parameters, 0xDEADBEEF, byte_out_ready held 1 → bytes 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A on cycles N+1..N+10. word_in_ready = 1 again at N+11.
- byte_out_ready pseudo-random at about 50% → same 10-byte sequence. byte_out_data is stable and byte_out_valid stays high across every stalled cycle.
- UPPERCASE=0, EMIT_CRLF=0, input 0x0000ABCD → exactly 8 bytes, 0x30 0x30 0x30 0x30 0x61 0x62 0x63 0x64, then IDLE with no CR/LF.
- word_in_valid held high with back-to-back words 0x00000001 then 0xFFFFFFFF → second word is not accepted until after the LF of the first. The output reads "00000001\r\nFFFFFFFF\r\n".
- WORD_WIDTH=8, input 0x5A → 0x35 0x41 0x0D 0x0A.
- rst pulsed for 1 cycle after the third digit of 0x12345678 → byte_out_valid = 0 the next cycle and no further digits. A following word 0x9 → "00000009\r\n" complete.
